// File: rtl/sfx_pkg.sv
// Shared definitions for the sound-effect player: event indices, event table
// layout, default table and width helpers.
package sfx_pkg;

  localparam int DIV_W = 16;
  localparam int DUR_W = 10;
  localparam int VOL_W = 4;

  localparam int EV_PADDLE = 0;
  localparam int EV_BRICK  = 1;
  localparam int EV_WALL   = 2;
  localparam int EV_LOST   = 3;

  typedef struct packed {
    logic [DIV_W-1:0] half_period;
    logic [DUR_W-1:0] duration;
    logic [VOL_W-1:0] volume;
  } ev_t;

  typedef ev_t [3:0] ev_table4_t;

  function automatic ev_t mk_ev(input int unsigned hp, input int unsigned dur,
                                input int unsigned vol);
    ev_t e;
    e.half_period = DIV_W'(hp);
    e.duration    = DUR_W'(dur);
    e.volume      = VOL_W'(vol);
    return e;
  endfunction

  // Half-periods assume the 40 MHz system clock.
  function automatic ev_table4_t default_table();
    ev_table4_t t;
    t[EV_PADDLE] = mk_ev(45454, 60, 12);
    t[EV_BRICK]  = mk_ev(22727, 40, 10);
    t[EV_WALL]   = mk_ev(30303, 30, 8);
    t[EV_LOST]   = mk_ev(60000, 500, 15);
    return t;
  endfunction

  localparam ev_table4_t DEFAULT_TABLE = default_table();

  function automatic int mix_w(input int num_voices);
    return VOL_W + $clog2(num_voices + 1);
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sfx_voice.sv
// One tone voice: half-period divider, ms duration counter, square output
// and IDLE/PLAY state.
module sfx_voice
  import sfx_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] half_period,
  input  logic [DUR_W-1:0] duration,
  input  logic [VOL_W-1:0] volume,
  input  logic             tick,
  output logic             busy,
  output logic [DUR_W-1:0] remaining,
  output logic [VOL_W-1:0] level
);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t           state, state_nx;
  logic [DIV_W-1:0] hp_q, hp_nx, div_q, div_nx;
  logic [DUR_W-1:0] dur_q, dur_nx;
  logic [VOL_W-1:0] vol_q, vol_nx;
  logic             sq_q, sq_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      hp_q  <= '0;
      div_q <= '0;
      dur_q <= '0;
      vol_q <= '0;
      sq_q  <= 1'b0;
    end else begin
      state <= state_nx;
      hp_q  <= hp_nx;
      div_q <= div_nx;
      dur_q <= dur_nx;
      vol_q <= vol_nx;
      sq_q  <= sq_nx;
    end
  end

  // A load overrides everything else, including expiry in the same cycle.
  always_comb begin
    state_nx = state;
    hp_nx    = hp_q;
    div_nx   = div_q;
    dur_nx   = dur_q;
    vol_nx   = vol_q;
    sq_nx    = sq_q;
    if (load) begin
      state_nx = PLAY;
      hp_nx    = half_period;
      div_nx   = (half_period == '0) ? '0 : half_period - 1'b1;
      dur_nx   = duration;
      vol_nx   = volume;
      sq_nx    = 1'b0;
    end else if (state == PLAY) begin
      if (dur_q == '0) begin
        state_nx = IDLE;
        sq_nx    = 1'b0;
      end else begin
        if (tick) dur_nx = dur_q - 1'b1;
        if (hp_q != '0) begin
          if (div_q == '0) begin
            sq_nx  = ~sq_q;
            div_nx = hp_q - 1'b1;
          end else begin
            div_nx = div_q - 1'b1;
          end
        end
      end
    end
  end

  assign busy      = (state == PLAY);
  assign remaining = dur_q;
  assign level     = sq_q ? vol_q : '0;

endmodule

// File: rtl/sfx_player.sv
// Event-triggered multi-voice sound-effect player: request queue, voice
// allocator, 1 ms prescaler, mixer and first-order sigma-delta output.
module sfx_player
  import sfx_pkg::*;
#(
  parameter int unsigned          CLK_HZ     = 40_000_000,
  parameter int unsigned          NUM_VOICES = 4,
  parameter int unsigned          NUM_EVENTS = 4,
  parameter ev_t [NUM_EVENTS-1:0] EV_TABLE   = DEFAULT_TABLE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_EVENTS-1:0] trigger,
  input  logic                  mute,
  output logic [NUM_VOICES-1:0] busy,
  output logic                  audio
);

  localparam int unsigned TICK_DIV = CLK_HZ / 1000;
  localparam int          MIX_W    = mix_w(NUM_VOICES);
  localparam int          EV_W     = idx_w(NUM_EVENTS);
  localparam int          VI_W     = idx_w(NUM_VOICES);

  logic [31:0]           presc;
  logic                  tick;
  logic [NUM_EVENTS-1:0] pending, req, served;
  logic [EV_W-1:0]       ev_sel;
  logic                  ev_valid;
  ev_t                   ev;
  logic [NUM_VOICES-1:0] load;
  logic [EV_W-1:0]       voice_ev  [NUM_VOICES];
  logic [DUR_W-1:0]      remaining [NUM_VOICES];
  logic [VOL_W-1:0]      level     [NUM_VOICES];
  logic                  hit, idle_found;
  logic [VI_W-1:0]       hit_v, idle_v, steal_v, alloc_v;
  logic [DUR_W-1:0]      best;
  logic [MIX_W-1:0]      mix, acc;
  logic [MIX_W:0]        acc_sum;

  assign tick = (presc == TICK_DIV - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  always_comb begin
    req      = pending | trigger;
    served   = '0;
    ev_sel   = '0;
    ev_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
      if (req[i] && !ev_valid) begin
        served[i] = 1'b1;
        ev_sel    = EV_W'(i);
        ev_valid  = 1'b1;
      end
    end
  end

  assign ev = EV_TABLE[ev_sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= req & ~served;
  end

  // Priority: restart same event, else lowest idle, else shortest remaining.
  always_comb begin
    hit        = 1'b0;
    hit_v      = '0;
    idle_found = 1'b0;
    idle_v     = '0;
    steal_v    = '0;
    best       = '1;
    load       = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      if (busy[v] && voice_ev[v] == ev_sel && !hit) begin
        hit   = 1'b1;
        hit_v = VI_W'(v);
      end
      if (!busy[v] && !idle_found) begin
        idle_found = 1'b1;
        idle_v     = VI_W'(v);
      end
      if (remaining[v] < best) begin
        best    = remaining[v];
        steal_v = VI_W'(v);
      end
    end
    alloc_v = hit ? hit_v : (idle_found ? idle_v : steal_v);
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      load[v] = ev_valid && (ev.duration != '0) && (alloc_v == VI_W'(v));
    end
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       voice_ev[v] <= '0;
      else if (load[v]) voice_ev[v] <= ev_sel;
    end

    sfx_voice u_voice (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (load[v]),
      .half_period (ev.half_period),
      .duration    (ev.duration),
      .volume      (ev.volume),
      .tick        (tick),
      .busy        (busy[v]),
      .remaining   (remaining[v]),
      .level       (level[v])
    );
  end

  always_comb begin
    mix = '0;
    if (!mute) begin
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        mix = mix + MIX_W'(level[v]);
      end
    end
  end

  assign acc_sum = {1'b0, acc} + {1'b0, mix};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      audio <= 1'b0;
    end else begin
      acc   <= acc_sum[MIX_W-1:0];
      audio <= acc_sum[MIX_W];
    end
  end

endmodule

// File: tb/tb_sfx_player.sv
// Directed self-checking bench for sfx_player with a 100-cycle ms tick and a
// small event table; a second 2-voice instance exercises voice stealing.
module tb_sfx_player;
  import sfx_pkg::*;

  localparam ev_table4_t TB_TABLE = {mk_ev(0, 0, 0), mk_ev(0, 1, 5),
                                     mk_ev(8, 2, 8), mk_ev(4, 3, 15)};

  logic       clk, rst_n, mute, audio, mute2, audio2;
  logic [3:0] trigger, busy, trigger2;
  logic [1:0] busy2;

  int          checks = 0;
  int          errors = 0;
  int          cyc;
  int          cnt, e, ld, ld2, ls;
  logic [15:0] pat;
  logic [2:0]  extra;

  sfx_player #(
    .CLK_HZ     (100_000),
    .NUM_VOICES (4),
    .NUM_EVENTS (4),
    .EV_TABLE   (TB_TABLE)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .trigger (trigger),
    .mute    (mute),
    .busy    (busy),
    .audio   (audio)
  );

  sfx_player #(
    .CLK_HZ     (100_000),
    .NUM_VOICES (2),
    .NUM_EVENTS (4),
    .EV_TABLE   (TB_TABLE)
  ) dut2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .trigger (trigger2),
    .mute    (mute2),
    .busy    (busy2),
    .audio   (audio2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter since reset release; tick edges are the multiples of 100.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  function automatic int fall_edge(input int load_edge, input int dur);
    return (load_edge / 100 + 1) * 100 + (dur - 1) * 100 + 1;
  endfunction

  task automatic wait_mod(input int m);
    for (int i = 0; i < 100 && (cyc % 100) != m; i++) step();
  endtask

  task automatic wait_fall(input int b, input int bound, output int edge_o);
    edge_o = -1;
    for (int i = 0; i <= bound; i++) begin
      if (!busy[b]) begin
        edge_o = cyc;
        break;
      end
      step();
    end
  endtask

  task automatic wait_change2(input logic [1:0] from, input int bound, output int edge_o);
    edge_o = -1;
    for (int i = 0; i <= bound; i++) begin
      if (busy2 != from) begin
        edge_o = cyc;
        break;
      end
      step();
    end
  endtask

  initial begin
    rst_n = 1'b0; trigger = '0; mute = 1'b0; trigger2 = '0; mute2 = 1'b0;
    #1;
    check("reset_busy", 32'(busy), 0);
    check("reset_audio", 32'(audio), 0);
    check("reset_busy2", 32'(busy2), 0);
    repeat (3) step();
    rst_n = 1'b1;

    cnt = 0;
    repeat (1000) begin step(); cnt += int'(audio); end
    check("idle_audio", 32'(cnt), 0);
    check("idle_busy", 32'(busy), 0);

    // single EV0
    trigger = 4'b0001; step(); ld = cyc; trigger = '0;
    check("ev0_busy", 32'(busy), 1);
    pat = '0;
    for (int k = 0; k < 16; k++) begin
      pat[k] = (dut.level[0] != '0);
      if (k < 15) step();
    end
    check("ev0_square", 32'(pat), 32'hF0F0);
    cnt = 0;
    repeat (176) begin step(); cnt += int'(audio); end
    check_rng("ev0_duty", cnt, 10, 11);
    wait_fall(0, 300, e);
    check("ev0_end", 32'(e), 32'(fall_edge(ld, 3)));
    repeat (2) step();
    cnt = 0;
    repeat (50) begin step(); cnt += int'(audio); end
    check("post_idle_audio", 32'(cnt), 0);

    // simultaneous EV0+EV1, then ignored EV3
    trigger = 4'b0011; step(); ld = cyc; trigger = '0;
    check("dual_first", 32'(busy), 1);
    step();
    check("dual_second", 32'(busy), 3);
    trigger = 4'b1000; step(); trigger = '0; step();
    check("ev3_ignored", 32'(busy), 3);
    wait_fall(1, 300, e);
    check("dual_ev1_end", 32'(e), 32'(fall_edge(ld + 1, 2)));
    wait_fall(0, 300, e);
    check("dual_ev0_end", 32'(e), 32'(fall_edge(ld, 3)));

    // retrigger EV0 while playing
    trigger = 4'b0001; step(); trigger = '0;
    repeat (150) step();
    trigger = 4'b0001; step(); ld2 = cyc; trigger = '0;
    check("retrig_busy", 32'(busy), 1);
    e = -1; extra = '0;
    for (int i = 0; i <= 400; i++) begin
      extra |= busy[3:1];
      if (!busy[0]) begin e = cyc; break; end
      step();
    end
    check("retrig_end", 32'(e), 32'(fall_edge(ld2, 3)));
    check("retrig_no_extra", 32'(extra), 0);

    // mute during play
    trigger = 4'b0001; step(); ld = cyc; trigger = '0;
    repeat (3) step();
    mute = 1'b1; step();
    cnt = 0;
    repeat (100) begin step(); cnt += int'(audio); end
    check("mute_audio", 32'(cnt), 0);
    check("mute_busy", 32'(busy), 1);
    mute = 1'b0;
    cnt = 0;
    repeat (64) begin step(); cnt += int'(audio); end
    check_rng("unmute_duty", cnt, 3, 4);
    wait_fall(0, 300, e);
    check("mute_no_restart", 32'(e), 32'(fall_edge(ld, 3)));

    // steal: smaller remaining wins
    wait_mod(10);
    trigger2 = 4'b0010; step();
    trigger2 = 4'b0001; step();
    trigger2 = 4'b0100; step(); ls = cyc; trigger2 = '0;
    check("steal_busy", 32'(busy2), 3);
    wait_change2(2'b11, 300, e);
    check("steal_victim", 32'(busy2), 2);
    check("steal_end", 32'(e), 32'(fall_edge(ls, 1)));
    for (int i = 0; i < 400 && busy2 != '0; i++) step();
    check("steal_idle", 32'(busy2), 0);

    // steal: equal remaining -> lowest index
    wait_mod(10);
    trigger2 = 4'b0001; step(); trigger2 = '0;
    wait_mod(0);
    wait_mod(10);
    trigger2 = 4'b0010; step();
    trigger2 = 4'b0100; step(); ls = cyc; trigger2 = '0;
    check("tie_busy", 32'(busy2), 3);
    wait_change2(2'b11, 300, e);
    check("tie_victim", 32'(busy2), 2);
    check("tie_end", 32'(e), 32'(fall_edge(ls, 1)));

    // asynchronous reset mid-tone
    trigger = 4'b0001; step(); trigger = '0;
    repeat (20) step();
    check("pre_reset_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_busy", 32'(busy), 0);
    check("async_reset_audio", 32'(audio), 0);
    check("async_reset_busy2", 32'(busy2), 0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (5) step();
    check("after_release_busy", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
